spi_master_word: RTL and testbench
==================================

Name: spi_master_word

Overview:
Parametrised successor to the byte-wide SPI master. Runtime-selectable SPI mode (CPOL/CPHA) and bit order; word width set by parameter. Integrated multi-slave chip-select with back-to-back words kept inside one CS frame. Sits between the LCD/peripheral controller FSMs and the SPI pins.

Parameters:
DATA_W, 8, bits per word (2..32)
NUM_CS, 1, number of chip-select outputs (1..8)
DIV_W, 16, width of clk_div
CS_IDX_W, 1, width of cs_sel (must satisfy 2**CS_IDX_W >= NUM_CS)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_div  in  DIV_W  clk cycles per SCK half-period (D); 0 treated as 1
cpol  in  1  SCK idle level; latched at frame start
cpha  in  1  0: sample leading/shift trailing; 1: shift leading/sample trailing; latched at frame start
lsb_first  in  1  bit order; latched at every word accept
cs_sel  in  CS_IDX_W  slave index; latched at frame start
start  in  1  request one word; accepted only in IDLE or WAIT
last  in  1  sampled with start; 1 = release CS after this word
tx_data  in  DATA_W  word to send; latched at accept
rx_data  out  DATA_W  received word; updated on the done cycle
done  out  1  one-cycle pulse when word complete
busy  out  1  high from accept until state is IDLE or WAIT
sck  out  1  SPI clock
mosi  out  1  SPI data out
miso  in  1  SPI data in
cs_n  out  NUM_CS  active-low chip selects, one-hot-low or all high

Behaviour:
- Reset (takes priority over all): state IDLE, sck=0, mosi=0, cs_n all 1, rx_data=0, done=0, busy=0, latched cpol=0. Reset mid-word aborts immediately, with no done pulse.
- States: IDLE, SETUP, SHIFT, HOLD, WAIT.
- IDLE: sck=latched cpol, cs_n all 1. On start: latch cpol/cpha/cs_sel/lsb_first/tx_data/last, busy<=1, go to SETUP.
- SETUP: cs_n[cs_sel] low, D cycles. If cpha=0, mosi = first bit on SETUP entry. Then go to SHIFT.
- SHIFT: 2*DATA_W half-periods of D cycles each. Every half-period boundary toggles sck: odd toggles are leading edges, even toggles are trailing edges.
  - cpha=0: sample miso on leading edges; drive the next bit on trailing edges, except after the final bit.
  - cpha=1: drive a bit on each leading edge; sample on each trailing edge.
  - After the 2*DATA_W-th edge, sck is back at cpol. Then: rx_data<=shift reg, done<=1 (one cycle), go to HOLD.
- First bit is tx_data[DATA_W-1] if lsb_first=0, else tx_data[0]. Received bits are placed symmetrically, so a loopback miso=mosi gives rx_data==tx_data in both orders.
- HOLD: D cycles with CS still asserted.
  - last=1: cs_n all high, busy<=0, go to IDLE.
  - last=0: busy<=0, go to WAIT with CS held.
- WAIT: CS held, sck=cpol. On start: latch tx_data/lsb_first/last only (cpol/cpha/cs_sel ignored), go directly to SETUP.
- Latency with D≥1: done is high exactly 1+D+2*DATA_W*D cycles after the clk edge that accepted start. Frame end is D cycles later.
- start while busy: ignored, with no side effects.
- start in the same cycle as done: ignored. Accept is possible only from IDLE/WAIT.
- cs_sel ≥ NUM_CS: transfer runs normally, no cs_n asserted.
- Counters: the divider counts 0..D-1. The bit counter is $clog2(DATA_W) wide with no wrap beyond DATA_W.
- Changing clk_div mid-word takes effect at the next half-period boundary.

Decomposition:
- Shared package spi_pkg holds: state encoding constants (ST_IDLE..ST_WAIT), SPI mode constants (MODE0..MODE3 = {cpol,cpha}), and the clk_div==0→1 rule as a function.
- One natural sub-module: spi_clk_div. It holds the half-period counter and emits a tick when count == D-1, with synchronous clear on reset or IDLE.

Test Plan:
- DATA_W=8, D=2, mode 0, MSB first, tx=0xA5, miso looped to mosi → mosi sequence 1,0,1,0,0,1,0,1 on rising edges; rx_data=0xA5; done at 1+2+32=35 cycles; cs_n[0] low until 2 cycles after done.
- DATA_W=16, mode 3 (cpol=1, cpha=1), lsb_first=1, tx=0x1234, miso tied 1 → sck idles 1; bits driven LSB first on falling edges; rx_data=0xFFFF.
- NUM_CS=4, cs_sel=2, two words 0x11 (last=0) then 0x22 (last=1) → cs_n=4'b1011 continuously across both words; busy=0 in WAIT; cs_n=4'hF after the second HOLD.
- start pulsed at cycles 3 and 10 of an active word, and in the same cycle as done → no effect on mosi/rx_data; exactly one done pulse.
- reset asserted mid-SHIFT (bit 4 of 8) → next cycle: sck=0, cs_n all 1, busy=0, no done; a new start afterwards completes correctly.
- clk_div=0 → behaves identically to clk_div=1: done 1+1+16=18 cycles after accept for DATA_W=8.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the word-wide SPI master: state encoding, SPI mode codes
// and the divider rule that treats a zero clk_div as one.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_WAIT  = 3'd4
  } state_e;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: ticks on the last cycle of each D-cycle half-period.
// Synchronously cleared while the master is idle, waiting, or restarting a phase.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] d_eff;
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign d_eff = DIV_W'(eff_div(32'(div)));

  // >= rather than == so a mid-word shrink of clk_div cannot strand the counter
  assign tick = !clear && (cnt_q >= d_eff - DIV_W'(1));

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_word.sv
// Word-wide SPI master with runtime mode and bit order, multi-slave chip select,
// and back-to-back words kept inside one CS frame until a word flagged last.
module spi_master_word
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_CS   = 1,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned CS_IDX_W = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DIV_W-1:0]    clk_div,
  input  logic                cpol,
  input  logic                cpha,
  input  logic                lsb_first,
  input  logic [CS_IDX_W-1:0] cs_sel,
  input  logic                start,
  input  logic                last,
  input  logic [DATA_W-1:0]   tx_data,
  output logic [DATA_W-1:0]   rx_data,
  output logic                done,
  output logic                busy,
  output logic                sck,
  output logic                mosi,
  input  logic                miso,
  output logic [NUM_CS-1:0]   cs_n
);

  localparam int unsigned BitW = $clog2(DATA_W);

  state_e              state_q, state_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d, last_q, last_d;
  logic                fin_q, fin_d, sck_q, sck_d, mosi_q, mosi_d;
  logic                done_q, done_d, busy_q, busy_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d, rx_sr_q, rx_sr_d, rx_data_q, rx_data_d;
  logic [BitW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
  logic                tick, div_clear, accept, cpha_eff, final_bit;

  function automatic logic head(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // Received bits enter from the side opposite the transmit head, so loopback round-trips.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic lsb,
                                                 input logic b);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  assign div_clear = reset || (state_q == ST_IDLE) || (state_q == ST_WAIT) || fin_q;
  assign accept    = start && ((state_q == ST_IDLE) || (state_q == ST_WAIT));
  assign cpha_eff  = (state_q == ST_IDLE) ? cpha : cpha_q;
  assign final_bit = (bit_cnt_q == BitW'(DATA_W - 1));

  spi_clk_div #(
    .DIV_W(DIV_W)
  ) u_clk_div (
    .clk  (clk),
    .clear(div_clear),
    .div  (clk_div),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    last_d    = last_q;
    fin_d     = fin_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    cs_n_d    = cs_n_q;

    unique case (state_q)
      ST_IDLE: begin
        sck_d  = cpol_q;
        cs_n_d = '1;
        if (start) begin
          cpol_d = cpol;
          cpha_d = cpha;
          sck_d  = cpol;
          for (int i = 0; i < int'(NUM_CS); i++) cs_n_d[i] = (cs_sel != CS_IDX_W'(i));
        end
      end
      ST_WAIT:  sck_d = cpol_q;
      ST_SETUP: if (tick) state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (fin_q) begin
          fin_d     = 1'b0;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          state_d   = ST_HOLD;
        end else if (tick) begin
          sck_d = ~sck_q;
          if (sck_q == cpol_q) begin
            if (cpha_q) begin
              mosi_d  = head(tx_sr_q, lsb_q);
              tx_sr_d = shift_out(tx_sr_q, lsb_q);
            end else begin
              rx_sr_d = shift_in(rx_sr_q, lsb_q, miso);
            end
          end else begin
            if (cpha_q) begin
              rx_sr_d = shift_in(rx_sr_q, lsb_q, miso);
            end else if (!final_bit) begin
              mosi_d  = head(tx_sr_q, lsb_q);
              tx_sr_d = shift_out(tx_sr_q, lsb_q);
            end
            if (final_bit) fin_d = 1'b1;
            else           bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          busy_d  = 1'b0;
          state_d = last_q ? ST_IDLE : ST_WAIT;
          if (last_q) cs_n_d = '1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      lsb_d     = lsb_first;
      last_d    = last;
      busy_d    = 1'b1;
      bit_cnt_d = '0;
      fin_d     = 1'b0;
      state_d   = ST_SETUP;
      // cpha=0 presents the first bit before the leading edge
      if (!cpha_eff) begin
        mosi_d  = head(tx_data, lsb_first);
        tx_sr_d = shift_out(tx_data, lsb_first);
      end else begin
        tx_sr_d = tx_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      last_q    <= 1'b0;
      fin_q     <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      cs_n_q    <= '1;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      last_q    <= last_d;
      fin_q     <= fin_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      cs_n_q    <= cs_n_d;
    end
  end

  assign rx_data = rx_data_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;
  assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_word.sv
// Directed bench for spi_master_word: an 8-bit / 4-CS instance and a 16-bit / 1-CS
// instance share stimulus; expected values are hand-computed constants.
module tb_spi_master_word;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] div_s;
  logic        cpol_s, cpha_s, lsb_s, start_s, last_s, use16, loopback, miso_fix;
  logic [1:0]  cs_sel_s;
  logic [31:0] tx_s;

  logic [7:0]  rx8;
  logic [15:0] rx16;
  logic        done8, busy8, sck8, mosi8, done16, busy16, sck16, mosi16;
  logic [3:0]  cs_n8;
  logic [0:0]  cs_n16;

  logic        t_busy, t_done, t_sck, t_mosi;
  logic [31:0] t_rx;
  logic [3:0]  t_cs;

  int total = 0;
  int bad = 0;
  int lat, t_end, dones, cs_bad, cyc;
  logic [31:0] bits;

  always #5 clk = ~clk;

  assign t_busy = use16 ? busy16 : busy8;
  assign t_done = use16 ? done16 : done8;
  assign t_sck  = use16 ? sck16 : sck8;
  assign t_mosi = use16 ? mosi16 : mosi8;
  assign t_rx   = use16 ? {16'h0, rx16} : {24'h0, rx8};
  assign t_cs   = use16 ? {3'b111, cs_n16} : cs_n8;

  spi_master_word #(
    .DATA_W(8), .NUM_CS(4), .DIV_W(16), .CS_IDX_W(2)
  ) u_dut8 (
    .clk(clk), .reset(reset), .clk_div(div_s), .cpol(cpol_s), .cpha(cpha_s),
    .lsb_first(lsb_s), .cs_sel(cs_sel_s), .start(start_s & ~use16), .last(last_s),
    .tx_data(tx_s[7:0]), .rx_data(rx8), .done(done8), .busy(busy8), .sck(sck8),
    .mosi(mosi8), .miso(loopback ? mosi8 : miso_fix), .cs_n(cs_n8)
  );

  spi_master_word #(
    .DATA_W(16), .NUM_CS(1), .DIV_W(16), .CS_IDX_W(1)
  ) u_dut16 (
    .clk(clk), .reset(reset), .clk_div(div_s), .cpol(cpol_s), .cpha(cpha_s),
    .lsb_first(lsb_s), .cs_sel(cs_sel_s[0]), .start(start_s & use16), .last(last_s),
    .tx_data(tx_s[15:0]), .rx_data(rx16), .done(done16), .busy(busy16), .sck(sck16),
    .mosi(mosi16), .miso(loopback ? mosi16 : miso_fix), .cs_n(cs_n16)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One word: accept, then watch until busy drops (bounded), recording mosi at rising sck.
  task automatic xfer(input logic [31:0] tx, input logic lst, input logic inj,
                      input logic [3:0] cs_exp);
    logic prev;
    tx_s = tx; last_s = lst; start_s = 1'b1;
    step();
    start_s = 1'b0;
    cyc = 0; lat = -1; t_end = -1; dones = 0; cs_bad = 0; bits = 0;
    prev = t_sck;
    while (t_busy && cyc < 2000) begin
      if (t_cs !== cs_exp) cs_bad++;
      if (t_done) begin
        dones++;
        if (lat < 0) lat = cyc;
        if (inj) start_s = 1'b1;
      end
      if (!prev && t_sck) bits = {bits[30:0], t_mosi};
      prev = t_sck;
      if (inj && (cyc == 3 || cyc == 10)) begin
        start_s = 1'b1; tx_s = 32'hFFFF_FFFF;
      end
      step();
      cyc++;
      start_s = 1'b0; tx_s = tx;
    end
    t_end = t_busy ? -1 : cyc;
    for (int i = 0; i < 4; i++) begin
      if (t_done) dones++;
      step();
    end
  endtask

  initial begin
    int extra_done;
    use16 = 1'b0; loopback = 1'b1; miso_fix = 1'b0;
    div_s = 16'd2; cpol_s = 1'b0; cpha_s = 1'b0; lsb_s = 1'b0;
    cs_sel_s = 2'd0; start_s = 1'b0; last_s = 1'b1; tx_s = '0;
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    step();
    check_eq("rst_sck", 32'(sck8), 32'd0);
    check_eq("rst_cs_n", 32'(cs_n8), 32'hF);
    check_eq("rst_busy", 32'(busy8), 32'd0);
    check_eq("rst_done", 32'(done8), 32'd0);
    check_eq("rst_rx", 32'(rx8), 32'd0);
    check_eq("rst_mosi", 32'(mosi8), 32'd0);

    // Mode 0, MSB first, loopback, D=2
    xfer(32'hA5, 1'b1, 1'b0, 4'b1110);
    check_eq("m0_latency", 32'(lat), 32'd35);
    check_eq("m0_frame_end", 32'(t_end), 32'd37);
    check_eq("m0_mosi_bits", bits, 32'hA5);
    check_eq("m0_rx", t_rx, 32'hA5);
    check_eq("m0_dones", 32'(dones), 32'd1);
    check_eq("m0_cs_during", 32'(cs_bad), 32'd0);
    check_eq("m0_cs_after", 32'(t_cs), 32'hF);

    // Mode 3, LSB first, 16-bit, miso tied high, D=1
    use16 = 1'b1; loopback = 1'b0; miso_fix = 1'b1;
    div_s = 16'd1; cpol_s = 1'b1; cpha_s = 1'b1; lsb_s = 1'b1;
    xfer(32'h1234, 1'b1, 1'b0, 4'b1110);
    check_eq("m3_latency", 32'(lat), 32'd34);
    check_eq("m3_mosi_bits", bits, 32'h2C48);
    check_eq("m3_rx", t_rx, 32'hFFFF);
    check_eq("m3_dones", 32'(dones), 32'd1);
    check_eq("m3_sck_idle", 32'(t_sck), 32'd1);

    // Two words in one CS frame on slave 2; frame-level settings ignored from WAIT
    use16 = 1'b0; loopback = 1'b1; miso_fix = 1'b0;
    div_s = 16'd2; cpol_s = 1'b0; cpha_s = 1'b0; lsb_s = 1'b0; cs_sel_s = 2'd2;
    xfer(32'h11, 1'b0, 1'b0, 4'b1011);
    check_eq("w1_latency", 32'(lat), 32'd35);
    check_eq("w1_rx", t_rx, 32'h11);
    check_eq("w1_cs_during", 32'(cs_bad), 32'd0);
    check_eq("wait_busy", 32'(t_busy), 32'd0);
    check_eq("wait_cs", 32'(t_cs), 32'b1011);
    check_eq("wait_sck", 32'(t_sck), 32'd0);
    cs_sel_s = 2'd0; cpol_s = 1'b1;
    xfer(32'h22, 1'b1, 1'b0, 4'b1011);
    check_eq("w2_latency", 32'(lat), 32'd35);
    check_eq("w2_rx", t_rx, 32'h22);
    check_eq("w2_mosi_bits", bits, 32'h22);
    check_eq("w2_cs_during", 32'(cs_bad), 32'd0);
    check_eq("w2_cs_after", 32'(t_cs), 32'hF);
    cpol_s = 1'b0;

    // Stray starts during the word and in the done cycle
    xfer(32'h3C, 1'b1, 1'b1, 4'b1110);
    check_eq("inj_latency", 32'(lat), 32'd35);
    check_eq("inj_rx", t_rx, 32'h3C);
    check_eq("inj_mosi_bits", bits, 32'h3C);
    check_eq("inj_dones", 32'(dones), 32'd1);
    check_eq("inj_idle_busy", 32'(t_busy), 32'd0);

    // Reset in the middle of bit 4
    tx_s = 32'hA5; last_s = 1'b1; start_s = 1'b1;
    step();
    start_s = 1'b0;
    repeat (18) step();
    check_eq("mid_busy_before", 32'(t_busy), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("mid_rst_sck", 32'(t_sck), 32'd0);
    check_eq("mid_rst_cs", 32'(t_cs), 32'hF);
    check_eq("mid_rst_busy", 32'(t_busy), 32'd0);
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      if (t_done) extra_done++;
      step();
    end
    check_eq("mid_no_done", 32'(extra_done), 32'd0);
    xfer(32'h96, 1'b1, 1'b0, 4'b1110);
    check_eq("post_rst_latency", 32'(lat), 32'd35);
    check_eq("post_rst_rx", t_rx, 32'h96);

    // clk_div = 0 behaves as 1
    div_s = 16'd0;
    xfer(32'h5A, 1'b1, 1'b0, 4'b1110);
    check_eq("d0_latency", 32'(lat), 32'd18);
    check_eq("d0_frame_end", 32'(t_end), 32'd19);
    check_eq("d0_rx", t_rx, 32'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
